// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, FSM states, default width.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  // funct-derived op encodings, shared with ALU-control decode
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, opnd};
    q_bit    = 1'b0;
    acc_next = acc;
    if (is_div) begin
      // remainder stays below the divisor, so a kept partial remainder fits WIDTH bits
      q_bit    = ~diff[WIDTH];
      acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer: magnitude datapath, sign fix-up, HI/LO registers.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e               state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc, acc_step;
  logic [WIDTH-1:0]     opnd, a_mag, b_mag;
  logic [WIDTH-1:0]     fix_hi, fix_lo;
  logic                 is_div, neg_q, neg_r, div0, q_bit;
  logic                 sgn, accept;

  assign sgn    = ~op[0];
  assign a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
  assign accept = start && !flush && (state == IDLE || state == DONE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .is_div   (is_div),
    .acc_next (acc_step),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (accept) state_nx = CALC;
      CALC: begin
        busy = 1'b1;
        if (flush)          state_nx = IDLE;
        else if (cnt == '0) state_nx = FIXUP;
      end
      FIXUP: begin
        busy     = 1'b1;
        state_nx = flush ? IDLE : DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = accept ? CALC : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Divide-by-zero: quotient is all ones unsigned; the remainder magnitude is |a|,
  // so restoring its sign yields the raw operand.
  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (!is_div) begin
      if (neg_q) {fix_hi, fix_lo} = -acc;
    end else begin
      if (neg_q && !div0) fix_lo = -acc[WIDTH-1:0];
      if (neg_r)          fix_hi = -acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (accept) begin
      cnt    <= CNT_W'(WIDTH - 1);
      acc    <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
      opnd   <= op[1] ? b_mag : a_mag;
      is_div <= op[1];
      neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= sgn & a[WIDTH-1];
      div0   <= op[1] && (b == '0);
    end else if (state == CALC) begin
      acc <= acc_step;
      cnt <= (flush || cnt == '0) ? '0 : cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIXUP && !flush) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops, back-to-back, flush and async reset.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_lat"}, cyc, e.cyc);
      end
    end
  end

  // call just after a negedge; start is sampled at the following posedge
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string name, input logic push,
                       input logic [31:0] eh, input logic [31:0] el);
    op = o; a = x; b = y; start = 1'b1;
    if (push) sb.push_back('{hi: eh, lo: el, cyc: cyc + 34, name: name});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input string name, input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    issue(o, x, y, name, 1'b1, eh, el);
    repeat (36) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000ns");
    $fatal(1);
  end

  initial begin
    int bad;
    int w;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk) rst_n = 1'b1;

    // MULT -3*7 with busy window over cycles 1..33 and done at 34
    @(negedge clk);
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7, "mult_neg", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (!busy) bad++;
    end
    chk("busy_window_gaps", bad, 0);
    @(negedge clk);
    chk("busy_in_done", busy, 0);
    chk("done_pulse", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    run(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 32'hFFFFFFFE, 32'h00000001);
    run(OP_DIVU, 32'd7, 32'd0, "divu_by0", 32'd7, 32'hFFFFFFFF);
    run(OP_DIV, 32'hFFFFFFF9, 32'd2, "div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 32'h00000000, 32'h80000000);
    run(OP_DIV, 32'hFFFFFFF9, 32'd0, "div_neg_by0", 32'hFFFFFFF9, 32'hFFFFFFFF);
    run(OP_DIV, 32'd7, 32'hFFFFFFFE, "div_negdiv", 32'd1, 32'hFFFFFFFD);

    // back-to-back: ignored start mid-op, then start during DONE
    @(negedge clk);
    issue(OP_MULTU, 32'd6, 32'd7, "b2b_first", 1'b1, 32'd0, 32'd42);
    repeat (9) @(negedge clk);
    issue(OP_DIV, 32'd1, 32'd1, "ignored", 1'b0, 32'd0, 32'd0);
    chk("busy_after_ignored", busy, 1);
    w = 0;
    while (!done && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("b2b_reach_done", done, 1);
    issue(OP_DIVU, 32'd100, 32'd7, "b2b_divu", 1'b1, 32'd2, 32'd14);
    repeat (36) @(negedge clk);

    // flush mid-CALC: no done, HI/LO keep 2/14
    @(negedge clk);
    issue(OP_MULT, 32'h1234, 32'h10, "flushed", 1'b0, 32'd0, 32'd0);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_hi", hi, 32'd2);
    chk("flush_lo", lo, 32'd14);
    repeat (40) @(negedge clk);
    chk("flush_hi_later", hi, 32'd2);

    // flush in IDLE blocks a simultaneous start
    @(negedge clk);
    flush = 1'b1;
    issue(OP_MULTU, 32'd1, 32'd1, "blocked", 1'b0, 32'd0, 32'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_blocks_start", busy, 0);

    // async reset mid-CALC clears outputs before the next edge
    @(negedge clk);
    issue(OP_MULT, 32'd5, 32'd5, "killed", 1'b0, 32'd0, 32'd0);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    chk("areset_hi", hi, 0);
    chk("areset_lo", lo, 0);
    @(negedge clk) rst_n = 1'b1;
    run(OP_MULT, 32'd3, 32'd5, "post_reset", 32'd0, 32'd15);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
